// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: iterative MIPS multiply/divide unit owning HI/LO, committing results atomically
module mips_cpu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       funct,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t state, state_nxt;
  logic [2*WIDTH-1:0] acc, prod;
  logic [WIDTH-1:0] x, y, a_mag, b_mag, quo, rem;
  logic [WIDTH:0] msum, rsh, dif;
  logic [CW-1:0] cnt;
  logic neg_q, neg_r, op_div, sgn, is_mul, is_div, go, last;
  assign sgn = ~funct[0];
  assign is_mul = funct[5:1] == 5'b01100;
  assign is_div = funct[5:1] == 5'b01101;
  assign go = start && state == IDLE;
  assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state != IDLE;
  assign msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, x & {WIDTH{y[0]}}};
  // Partial remainder shifted left with the next dividend bit; borrow means restore
  assign rsh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign dif = rsh - {1'b0, x};
  assign quo = acc[WIDTH-1:0];
  assign rem = acc[2*WIDTH-1:WIDTH];
  assign prod = neg_q ? -acc : acc;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     state_nxt = !start ? IDLE : is_mul ? MUL : is_div ? DIV : IDLE;
      MUL, DIV: state_nxt = last ? FIX : state;
      default:  state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
      acc <= '0;
      x <= '0;
      y <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      op_div <= 1'b0;
    end else begin
      done <= state == FIX;
      cnt <= state == IDLE ? '0 : cnt + 1'b1;
      if (go && funct == 6'b010001) hi <= a;
      if (go && funct == 6'b010011) lo <= a;
      if (go && is_mul) begin
        x <= a_mag;
        y <= b_mag;
        acc <= '0;
        neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
        op_div <= 1'b0;
      end
      // y keeps the raw dividend so divide-by-zero can return it untouched
      if (go && is_div) begin
        x <= b_mag;
        y <= a;
        acc <= {{WIDTH{1'b0}}, a_mag};
        neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r <= sgn && a[WIDTH-1];
        op_div <= 1'b1;
      end
      if (state == MUL) begin
        acc <= {msum, acc[WIDTH-1:1]};
        y <= y >> 1;
      end
      if (state == DIV) acc <= {dif[WIDTH] ? rsh[WIDTH-1:0] : dif[WIDTH-1:0], acc[WIDTH-2:0], ~dif[WIDTH]};
      if (state == FIX && !op_div) {hi, lo} <= prod;
      if (state == FIX && op_div) begin
        lo <= x == '0 ? '1 : neg_q ? -quo : quo;
        hi <= x == '0 ? y : neg_r ? -rem : rem;
      end
    end
endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// tb_mips_cpu_muldiv: scoreboard bench for the multiply/divide unit (32-bit and 8-bit instances)
module tb_mips_cpu_muldiv;
  localparam logic [5:0] MTHI = 6'b010001, MTLO = 6'b010011, MULT = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;
  logic clk = 0, reset = 1, start = 0, start8 = 0;
  logic [5:0] funct = 0, funct8 = 0;
  logic [31:0] a = 0, b = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic busy, done, busy8, done8;
  logic [31:0] hi, lo;
  logic [7:0] hi8, lo8;
  int n_chk = 0, n_fail = 0, cyc = 0, n_done = 0;
  typedef struct {
    logic [63:0] res;
    int t;
  } exp_t;
  exp_t sb[$];
  exp_t e_mon;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips_cpu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .funct(funct), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  mips_cpu_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .funct(funct8), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    logic signed [31:0] q, r;
    sx = $signed(x);
    sy = $signed(y);
    if (f == MULTU) return {32'b0, x} * {32'b0, y};
    if (f == MULT) return sx * sy;
    if (y == 0) return {x, 32'hFFFFFFFF};
    if (f == DIVU) return {x % y, x / y};
    if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
    q = $signed(x) / $signed(y);
    r = $signed(x) % $signed(y);
    return {r, q};
  endfunction

  always @(negedge clk)
    if (done) begin
      n_done++;
      if (sb.size() == 0) check("spurious_done", 1, 0);
      else begin
        e_mon = sb.pop_front();
        check("hilo", {hi, lo}, e_mon.res);
        check("latency", 64'(cyc - e_mon.t), 33);
        check("busy_in_done", busy, 0);
      end
    end

  // Called at a falling edge; returns 1 ns after the accepting rising edge
  task automatic issue(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    funct = f;
    a = x;
    b = y;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    funct = $urandom;
    a = $urandom;
    b = $urandom;
    if (f[5:2] == 4'b0110) sb.push_back('{model(f, x, y), cyc});
  endtask

  task automatic wait_done();
    for (int k = 0; k < 100 && !done; k++) @(negedge clk);
    if (!done) check("timeout", 0, 1);
  endtask

  task automatic run(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y, input logic [63:0] exp);
    issue(f, x, y);
    @(negedge clk);
    wait_done();
    check("spec_value", {hi, lo}, exp);
  endtask

  initial begin
    int n0, t8;
    logic [5:0] ops [4];
    logic [31:0] rx, ry;
    ops = '{MULT, MULTU, DIV, DIVU};
    repeat (2) @(negedge clk);
    check("reset_hilo", {hi, lo}, 0);
    check("reset_busy_done", {busy, done}, 0);
    reset = 0;
    @(negedge clk);
    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("hold_during_op", {hi, lo}, 0);
    wait_done();
    check("spec_value", {hi, lo}, 64'hFFFFFFFE_00000001);
    run(MULT, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1);
    run(DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    run(DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
    run(DIVU, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF});
    run(DIV, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000});
    run(DIV, 32'hFFFFFFF0, 32'd0, {32'hFFFFFFF0, 32'hFFFFFFFF});
    @(negedge clk);
    n0 = n_done;
    issue(MTHI, 32'h12345678, 32'd0);
    @(negedge clk);
    check("mthi", hi, 32'h12345678);
    check("mthi_no_done", 64'(n_done - n0), 0);
    issue(MULTU, 32'd7, 32'd9);
    repeat (3) @(negedge clk);
    issue(MTLO, 32'hDEADBEEF, 32'd0);
    @(negedge clk);
    wait_done();
    check("mtlo_while_busy", lo, 32'd63);
    @(negedge clk);
    issue(MULTU, 32'd7, 32'd9);
    repeat (9) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    sb.delete();
    check("abort_hilo", {hi, lo}, 0);
    check("abort_busy_done", {busy, done}, 0);
    n0 = n_done;
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(n_done - n0), 0);
    for (int i = 0; i < 8; i++) begin
      rx = $urandom;
      ry = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
      issue(ops[i % 4], rx, ry);
      @(negedge clk);
      wait_done();
    end
    funct8 = DIV;
    a8 = 8'h81;
    b8 = 8'h0A;
    start8 = 1;
    @(posedge clk);
    #1;
    start8 = 0;
    a8 = 8'h55;
    t8 = cyc;
    @(negedge clk);
    for (int k = 0; k < 30 && !done8; k++) @(negedge clk);
    check("w8_done", done8, 1);
    check("w8_latency", 64'(cyc - t8), 9);
    check("w8_div", {hi8, lo8}, 16'hF9F4);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
